// File: rtl/dfi_write_sequencer.sv
// ---------------------------------------------------------------------------
// dfi_write_sequencer
//
// Controller-side stage driving the DFI phase-0 inputs in 1:1 frequency-ratio
// mode. It accepts one write request at a time and issues the two-cycle DDR5
// write command. After the write latency it streams an 8-beat (BL16) or
// 16-beat (BL32) data burst, which it pulls from a valid/ready write-data source.
//
// Optional feature macro: DFI_SEQ_MASK_EN
//   defined   : dfi_wrdata_mask_p0 follows wmask_i per beat, all ones on
//               underflow beats
//   undefined : wmask_i is ignored and dfi_wrdata_mask_p0 is constant 0
//
// Parameters
//   pDRAM_SIZE : device width; data bus 2*pDRAM_SIZE, mask pDRAM_SIZE/4
//   pNUM_RANK  : number of ranks (chip-select width)
//   pWL        : cycles from command cycle 1 to first write-data enable (2..31)
//   pGAP       : idle cycles after the burst before the next accept (0..7)
//
// Ports
//   clk_i, rst_i                 : clock (rising edge), async active-low reset
//   req_valid_i / req_ready_o    : request handshake (ready only in IDLE)
//   req_rank_i, req_addr_i       : one-hot rank, bank/column address fields
//   req_bl32_i                   : 1 = BL32 (16 beats), 0 = BL16 (8 beats)
//   wdata_valid_i/wdata_ready_o  : write-data source handshake (ready = pop)
//   wdata_i, wmask_i             : beat data and mask
//   dfi_cs_n_p0, dfi_address_p0  : command outputs
//   dfi_wrdata_en_p0, dfi_wrdata_p0, dfi_wrdata_mask_p0 : data outputs
//   err_underflow_o              : sticky underflow flag, cleared by reset only
// ---------------------------------------------------------------------------
module dfi_write_sequencer #(
    parameter int pDRAM_SIZE = 4,
    parameter int pNUM_RANK  = 1,
    parameter int pWL        = 6,
    parameter int pGAP       = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [pNUM_RANK-1:0]      req_rank_i,
    input  logic [21:0]               req_addr_i,
    input  logic                      req_bl32_i,
    input  logic                      wdata_valid_i,
    output logic                      wdata_ready_o,
    input  logic [2*pDRAM_SIZE-1:0]   wdata_i,
    input  logic [pDRAM_SIZE/4-1:0]   wmask_i,
    output logic [pNUM_RANK-1:0]      dfi_cs_n_p0,
    output logic [13:0]               dfi_address_p0,
    output logic                      dfi_wrdata_en_p0,
    output logic [2*pDRAM_SIZE-1:0]   dfi_wrdata_p0,
    output logic [pDRAM_SIZE/4-1:0]   dfi_wrdata_mask_p0,
    output logic                      err_underflow_o
);

    localparam int DW = 2 * pDRAM_SIZE;
    localparam int MW = pDRAM_SIZE / 4;

    // WAIT lasts pWL-2 cycles, so the counter starts at pWL-3 and the state
    // leaves when it reads 0. Unused when pWL = 2 (WAIT skipped).
    localparam logic [4:0] WAIT_LOAD = 5'(pWL - 3);
    // GAP lasts pGAP cycles. Unused when pGAP = 0 (GAP skipped).
    localparam logic [2:0] GAP_LOAD  = 3'(pGAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD1,
        CMD2,
        WAIT,
        DATA,
        GAP
    } state_t;

    state_t              state_q, state_d;
    logic [pNUM_RANK-1:0] rank_q, rank_d;
    logic [21:0]         addr_q, addr_d;
    logic                bl32_q, bl32_d;
    logic [4:0]          waitCnt_q, waitCnt_d;
    logic [3:0]          beatCnt_q, beatCnt_d;
    logic [2:0]          gapCnt_q, gapCnt_d;

    logic                reqReady_q, reqReady_d;
    logic                wdReady_q, wdReady_d;
    logic [pNUM_RANK-1:0] csN_q, csN_d;
    logic [13:0]         address_q, address_d;
    logic                wrEn_q, wrEn_d;
    logic [DW-1:0]       wrData_q, wrData_d;
    logic [MW-1:0]       wrMask_q, wrMask_d;
    logic                underflow_q, underflow_d;

`ifndef DFI_SEQ_MASK_EN
    logic unusedWmask;
    assign unusedWmask = ^wmask_i;
`endif

    // Next-state logic. All outputs are registered, so each output's next
    // value is derived from the state being entered (state_d), not the
    // current one.
    always_comb begin
        state_d   = state_q;
        rank_d    = rank_q;
        addr_d    = addr_q;
        bl32_d    = bl32_q;
        waitCnt_d = waitCnt_q;
        beatCnt_d = beatCnt_q;
        gapCnt_d  = gapCnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i && reqReady_q) begin
                    state_d = CMD1;
                    rank_d  = req_rank_i;
                    addr_d  = req_addr_i;
                    bl32_d  = req_bl32_i;
                end
            end
            CMD1: state_d = CMD2;
            CMD2: begin
                if (pWL == 2) begin
                    state_d   = DATA;
                    beatCnt_d = bl32_q ? 4'd15 : 4'd7;
                end else begin
                    state_d   = WAIT;
                    waitCnt_d = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (waitCnt_q == 5'd0) begin
                    state_d   = DATA;
                    beatCnt_d = bl32_q ? 4'd15 : 4'd7;
                end else begin
                    waitCnt_d = waitCnt_q - 5'd1;
                end
            end
            DATA: begin
                if (beatCnt_q == 4'd0) begin
                    if (pGAP == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = GAP;
                        gapCnt_d = GAP_LOAD;
                    end
                end else begin
                    beatCnt_d = beatCnt_q - 4'd1;
                end
            end
            GAP: begin
                if (gapCnt_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    gapCnt_d = gapCnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        csN_d     = '1;
        address_d = '0;
        if (state_d == CMD1) begin
            csN_d     = ~rank_d;
            address_d = {addr_d[8:0], 5'b01101};
        end else if (state_d == CMD2) begin
            address_d = {bl32_q, addr_q[21:9]};
        end

        // A pop slot (wdReady_q) always precedes a DATA cycle, so the beat
        // taken in this cycle is exactly what the next DATA cycle presents.
        wrEn_d   = (state_d == DATA);
        wrData_d = '0;
        wrMask_d = '0;
        if (wdReady_q) begin
            if (wdata_valid_i) begin
                wrData_d = wdata_i;
            end
`ifdef DFI_SEQ_MASK_EN
            wrMask_d = wdata_valid_i ? wmask_i : '1;
`endif
        end
        underflow_d = underflow_q | (wdReady_q & ~wdata_valid_i);

        // Pop strobe runs one cycle ahead of each beat: the last cycle before
        // DATA plus every DATA cycle except the final one.
        wdReady_d = ((state_d == DATA) && (beatCnt_d != 4'd0)) ||
                    ((state_d == CMD2) && (pWL == 2)) ||
                    ((state_d == WAIT) && (waitCnt_d == 5'd0));
        reqReady_d = (state_d == IDLE);
    end

    // State and output registers; reset returns everything to idle values
    // immediately, abandoning any burst in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            rank_q      <= '0;
            addr_q      <= '0;
            bl32_q      <= 1'b0;
            waitCnt_q   <= '0;
            beatCnt_q   <= '0;
            gapCnt_q    <= '0;
            reqReady_q  <= 1'b0;
            wdReady_q   <= 1'b0;
            csN_q       <= '1;
            address_q   <= '0;
            wrEn_q      <= 1'b0;
            wrData_q    <= '0;
            wrMask_q    <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rank_q      <= rank_d;
            addr_q      <= addr_d;
            bl32_q      <= bl32_d;
            waitCnt_q   <= waitCnt_d;
            beatCnt_q   <= beatCnt_d;
            gapCnt_q    <= gapCnt_d;
            reqReady_q  <= reqReady_d;
            wdReady_q   <= wdReady_d;
            csN_q       <= csN_d;
            address_q   <= address_d;
            wrEn_q      <= wrEn_d;
            wrData_q    <= wrData_d;
            wrMask_q    <= wrMask_d;
            underflow_q <= underflow_d;
        end
    end

    assign req_ready_o        = reqReady_q;
    assign wdata_ready_o      = wdReady_q;
    assign dfi_cs_n_p0        = csN_q;
    assign dfi_address_p0     = address_q;
    assign dfi_wrdata_en_p0   = wrEn_q;
    assign dfi_wrdata_p0      = wrData_q;
    assign dfi_wrdata_mask_p0 = wrMask_q;
    assign err_underflow_o    = underflow_q;

endmodule
